// File: rtl/m10k_pkg.sv
// Shared types and helpers for the banked M10K reader/writer pair.
package m10k_pkg;

  localparam int N_BANKS_DEF = 16;
  localparam int W_DEF       = 8;
  localparam int DEPTH_DEF   = 1024;

  // Bank address width, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [W_DEF-1:0]                   bank_word_t;
  typedef bank_word_t [N_BANKS_DEF-1:0]       bank_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

endpackage

// File: rtl/m10k_bank_reader_skid_fifo2.sv
// Two-entry FIFO used to soak up the BRAM read latency plus one beat of
// downstream backpressure. Push into a full FIFO or pop from an empty one
// is never requested by the owner.
module skid_fifo2
  import m10k_pkg::*;
#(
  parameter int DW = N_BANKS_DEF * W_DEF + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [1:0]    o_occ
);

  logic [DW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_occ;

  // Storage, pointers and occupancy; push and pop in one cycle keep occ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head = r_mem[r_rptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/m10k_bank_reader.sv
// Read-side initiator for the banked M10K array: turns a (base, len) command
// into one N_BANKS-wide beat per address on a valid/ready stream. All banks
// are driven in lockstep; a 2-entry buffer hides the 1-cycle read latency
// and downstream stalls, and reads are only issued when a slot is guaranteed.
module m10k_bank_reader
  import m10k_pkg::*;
#(
  parameter int N_BANKS        = N_BANKS_DEF,
  parameter int W              = W_DEF,
  parameter int DEPTH_PER_BANK = DEPTH_DEF,
  parameter int AW             = addr_w(DEPTH_PER_BANK)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AW-1:0]         cmd_base,
  input  logic [AW:0]           cmd_len,
  output logic [N_BANKS-1:0]    rd_en,
  output logic [N_BANKS*AW-1:0] rd_addr,
  input  logic [N_BANKS*W-1:0]  rd_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [N_BANKS*W-1:0]  m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int DW = N_BANKS * W + 1;

  reader_state_e r_state;
  logic [AW-1:0] r_base;
  logic [AW:0]   r_len;
  logic [AW:0]   r_issued;
  logic          r_inflight;
  logic          r_inflight_last;
  logic          r_cmd_ready;
  logic          r_busy;
  logic          r_done;

  logic          w_pop;
  logic          w_issue;
  logic          w_issue_last;
  logic [1:0]    w_occ;
  logic [2:0]    w_pending;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_head;

  // A read may go out only if, after this cycle's pop, the buffer plus the
  // read already in flight still leaves room for its data next cycle.
  assign w_pop        = m_valid & m_ready;
  assign w_pending    = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_issue      = (r_state == RUN) && (r_issued < r_len) &&
                        (w_pending < (3'd2 + {2'b00, w_pop}));
  assign w_issue_last = (r_issued == r_len - 1'b1);
  // Address wraps naturally in AW bits.
  assign w_addr       = r_base + r_issued[AW-1:0];

  assign rd_en   = {N_BANKS{w_issue}};
  assign rd_addr = w_issue ? {N_BANKS{w_addr}} : '0;

  skid_fifo2 #(.DW(DW)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_inflight),
    .i_data ({r_inflight_last, rd_dout}),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_occ  (w_occ)
  );

  assign m_valid   = (w_occ != 2'd0);
  assign m_data    = w_head[DW-2:0];
  assign m_last    = w_head[DW-1];
  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;

  // Command FSM with registered handshake/status outputs and read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_base          <= '0;
      r_len           <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_cmd_ready     <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_issue_last;
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            if (cmd_len != '0) begin
              r_base      <= cmd_base;
              r_len       <= cmd_len;
              r_issued    <= '0;
              r_busy      <= 1'b1;
              r_cmd_ready <= 1'b0;
              r_state     <= RUN;
            end else begin
              // Empty command completes without touching the banks.
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_issued <= r_issued + 1'b1;
            if (w_issue_last) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && m_last) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m10k_bank_reader.sv
// Bench for m10k_bank_reader: bank memory model, randomized m_ready and
// commands, and an address/beat queue reference model.
module tb_m10k_bank_reader;

  localparam int NB    = 16;
  localparam int WW    = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = NB * WW;

  typedef logic [255:0] val_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_base;
  logic [AW:0]      cmd_len;
  logic [NB-1:0]    rd_en;
  logic [NB*AW-1:0] rd_addr;
  logic [DW-1:0]    rd_dout;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_data;
  logic             m_last;
  logic             busy;
  logic             done;

  m10k_bank_reader #(
    .N_BANKS(NB), .W(WW), .DEPTH_PER_BANK(DEPTH), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_dout(rd_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank array: registered read, one cycle after rd_en.
  logic [WW-1:0] mem [NB][DEPTH];
  initial rd_dout = '0;
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (rd_en[i]) rd_dout[i*WW +: WW] <= mem[i][rd_addr[i*AW +: AW]];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input val_t act, input val_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: expected address stream and beat stream.
  int            exp_addr[$];
  beat_t         exp_beat[$];
  logic [DW-1:0] cap[$];

  function automatic logic [DW-1:0] vec_at(input int a);
    logic [DW-1:0] v;
    for (int i = 0; i < NB; i++) v[i*WW +: WW] = mem[i][a];
    return v;
  endfunction

  task automatic model_cmd(input int base, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      int a;
      a = (base + k) % DEPTH;
      exp_addr.push_back(a);
      b.data = vec_at(a);
      b.last = (k == len - 1);
      exp_beat.push_back(b);
    end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < NB; i++)
      for (int a = 0; a < DEPTH; a++) mem[i][a] = 8'((i * 16 + a) & 255);
  endtask

  task automatic load_random();
    for (int i = 0; i < NB; i++)
      for (int a = 0; a < DEPTH; a++) mem[i][a] = 8'($urandom);
  endtask

  // m_ready driver: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  int rdy_mode = 0;
  int tgl = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       begin m_ready = (tgl % 3 == 0); tgl++; end
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  int            first_rd = -1, first_mv = -1, done_cyc = -1;
  int            done_cnt = 0, beat_cnt = 0, iss_cnt = 0, pop_cnt = 0;
  logic          prev_stall = 1'b0, prev_done = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          same;
  beat_t         eb;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en != '0) begin
        chk("rd_en_all", val_t'(rd_en), val_t'({NB{1'b1}}));
        same = 1'b1;
        for (int i = 0; i < NB; i++)
          if (rd_addr[i*AW +: AW] !== rd_addr[AW-1:0]) same = 1'b0;
        chk("rd_addr_lanes", val_t'(same), val_t'(1));
        chk("rd_en_expected", val_t'(exp_addr.size() > 0), val_t'(1));
        if (exp_addr.size() > 0)
          chk("rd_addr", val_t'(rd_addr[AW-1:0]), val_t'(exp_addr.pop_front()));
        iss_cnt++;
        // The banks sample this read on the next rising edge.
        if (first_rd < 0) first_rd = cyc + 1;
      end
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (prev_stall) begin
        chk("hold_valid", val_t'(m_valid), val_t'(1));
        chk("hold_data", val_t'(m_data), val_t'(prev_data));
        chk("hold_last", val_t'(m_last), val_t'(prev_last));
      end
      if (m_valid && m_ready) begin
        chk("beat_expected", val_t'(exp_beat.size() > 0), val_t'(1));
        if (exp_beat.size() > 0) begin
          eb = exp_beat.pop_front();
          chk("m_data", val_t'(m_data), val_t'(eb.data));
          chk("m_last", val_t'(m_last), val_t'(eb.last));
        end
        cap.push_back(m_data);
        pop_cnt++;
        beat_cnt++;
      end
      if (rd_en != '0) chk("outstanding_le2", val_t'((iss_cnt - pop_cnt) <= 2), val_t'(1));
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("busy_low_with_done", val_t'(busy), val_t'(0));
        chk("done_single_cycle", val_t'(prev_done), val_t'(0));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_done  = done;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      iss_cnt    = 0;
      pop_cnt    = 0;
      exp_addr.delete();
      exp_beat.delete();
    end
  end

  // Offer a command at the falling edge; acc = cycle index of the accepting edge.
  task automatic send_cmd(input int base, input int len, output int acc);
    int guard;
    first_rd = -1;
    first_mv = -1;
    done_cyc = -1;
    model_cmd(base, len);
    cmd_base  = AW'(base);
    cmd_len   = 11'(len);
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_accept_in_time", val_t'(cmd_ready), val_t'(1));
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int guard;
    guard = 0;
    while (done_cnt < target && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("done_in_time", val_t'(done_cnt >= target), val_t'(1));
    chk("beats_left", val_t'(exp_beat.size()), val_t'(0));
    chk("addrs_left", val_t'(exp_addr.size()), val_t'(0));
  endtask

  initial begin
    int acc, acc2, d, b0, iss0, guard, base, len;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    load_pattern();
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", val_t'(cmd_ready), val_t'(0));
    chk("rst_rd_en", val_t'(rd_en), val_t'(0));
    chk("rst_rd_addr", val_t'(rd_addr), val_t'(0));
    chk("rst_m_valid", val_t'(m_valid), val_t'(0));
    chk("rst_m_data", val_t'(m_data), val_t'(0));
    chk("rst_m_last", val_t'(m_last), val_t'(0));
    chk("rst_busy", val_t'(busy), val_t'(0));
    chk("rst_done", val_t'(done), val_t'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", val_t'(cmd_ready), val_t'(1));

    // Basic 4-beat read with full throughput.
    rdy_mode = 0;
    cap.delete();
    d = done_cnt;
    send_cmd(0, 4, acc);
    chk("busy_after_accept", val_t'(busy), val_t'(1));
    wait_done(d + 1);
    chk("first_rd_en_T+1", val_t'(first_rd), val_t'(acc + 1));
    chk("first_m_valid_T+2", val_t'(first_mv), val_t'(acc + 2));
    chk("done_T+6", val_t'(done_cyc), val_t'(acc + 6));
    chk("beat_count_4", val_t'(cap.size()), val_t'(4));
    if (cap.size() >= 3) chk("beat2_lane3", val_t'(cap[2][31:24]), val_t'(8'h32));

    // Address wrap at the top of the bank.
    d = done_cnt;
    send_cmd(1022, 4, acc);
    wait_done(d + 1);

    // Backpressure with m_ready 1,0,0 repeating.
    rdy_mode = 1;
    tgl = 0;
    cap.delete();
    d = done_cnt;
    send_cmd(100, 8, acc);
    wait_done(d + 1);
    chk("bp_beat_count_8", val_t'(cap.size()), val_t'(8));

    // Zero-length command.
    rdy_mode = 0;
    d = done_cnt;
    iss0 = iss_cnt;
    send_cmd(5, 0, acc);
    chk("zero_done_pulse", val_t'(done), val_t'(1));
    chk("zero_busy", val_t'(busy), val_t'(0));
    chk("zero_cmd_ready", val_t'(cmd_ready), val_t'(1));
    @(negedge clk);
    chk("zero_done_gone", val_t'(done), val_t'(0));
    chk("zero_m_valid", val_t'(m_valid), val_t'(0));
    chk("zero_no_reads", val_t'(iss_cnt), val_t'(iss0));
    chk("zero_done_count", val_t'(done_cnt), val_t'(d + 1));

    // Reset in the middle of an 8-beat stream.
    b0 = beat_cnt;
    d  = done_cnt;
    send_cmd(200, 8, acc);
    guard = 0;
    while (beat_cnt < b0 + 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("two_beats_before_rst", val_t'(beat_cnt >= b0 + 2), val_t'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd_en", val_t'(rd_en), val_t'(0));
    chk("abort_rd_addr", val_t'(rd_addr), val_t'(0));
    chk("abort_m_valid", val_t'(m_valid), val_t'(0));
    chk("abort_m_data", val_t'(m_data), val_t'(0));
    chk("abort_m_last", val_t'(m_last), val_t'(0));
    chk("abort_busy", val_t'(busy), val_t'(0));
    chk("abort_done", val_t'(done), val_t'(0));
    chk("abort_cmd_ready", val_t'(cmd_ready), val_t'(0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_done_after_abort", val_t'(done_cnt), val_t'(d));
    cap.delete();
    send_cmd(300, 2, acc);
    wait_done(d + 1);
    chk("post_rst_beats_2", val_t'(cap.size()), val_t'(2));

    // Back-to-back commands with random backpressure.
    load_random();
    rdy_mode = 2;
    d = done_cnt;
    send_cmd(500, 5, acc);
    chk("b2b_busy", val_t'(busy), val_t'(1));
    chk("b2b_cmd_ready_low", val_t'(cmd_ready), val_t'(0));
    send_cmd(1020, 6, acc2);
    chk("b2b_second_after_first", val_t'(acc2 > acc + 6), val_t'(1));
    wait_done(d + 2);

    // Random commands.
    for (int n = 0; n < 10; n++) begin
      base = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(0, 12);
      d    = done_cnt;
      send_cmd(base, len, acc);
      wait_done(d + 1);
    end

    repeat (5) @(negedge clk);
    chk("final_idle_busy", val_t'(busy), val_t'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
